// File: rtl/seq_div_32bit.sv
// Sequential 32-bit restoring divider with a start/busy/done handshake, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating toward zero); default is unsigned.
module seq_div_32bit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] input1,
   input  logic [31:0] input2,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [32:0] prem_q, prem_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] remo_q, remo_d;
   logic        dbz_q, dbz_d;

   logic [32:0] shifted;
   logic [32:0] trial;
   logic [32:0] nxt_rem;
   logic [31:0] nxt_dvd;

   // The partial remainder never exceeds the divisor, so its top bit stays clear.
   logic        unused_prem_msb;
   assign unused_prem_msb = prem_q[32];

`ifdef SEQ_DIV_SIGNED_EN
   logic qneg_q, qneg_d;
   logic rneg_q, rneg_d;

   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction
`endif

   assign shifted = {prem_q[31:0], dvd_q[31]};
   assign trial   = shifted + {1'b1, ~dvs_q} + 33'd1;
   assign nxt_rem = trial[32] ? shifted : trial;
   assign nxt_dvd = {dvd_q[30:0], ~trial[32]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (input2 == 32'd0) begin
                  quot_d  = 32'hFFFF_FFFF;
                  remo_d  = input1;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
`ifdef SEQ_DIV_SIGNED_EN
                  dvd_d  = input1[31] ? neg32(input1) : input1;
                  dvs_d  = input2[31] ? neg32(input2) : input2;
                  qneg_d = input1[31] ^ input2[31];
                  rneg_d = input1[31];
`else
                  dvd_d  = input1;
                  dvs_d  = input2;
`endif
                  prem_d  = 33'd0;
                  cnt_d   = 5'd0;
                  dbz_d   = 1'b0;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            prem_d = nxt_rem;
            dvd_d  = nxt_dvd;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
`ifdef SEQ_DIV_SIGNED_EN
               quot_d = qneg_q ? neg32(nxt_dvd) : nxt_dvd;
               remo_d = rneg_q ? neg32(nxt_rem[31:0]) : nxt_rem[31:0];
`else
               quot_d = nxt_dvd;
               remo_d = nxt_rem[31:0];
`endif
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         prem_q  <= 33'd0;
         dvd_q   <= 32'd0;
         dvs_q   <= 32'd0;
         quot_q  <= 32'd0;
         remo_q  <= 32'd0;
         dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign busy        = (state_q == S_BUSY);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;
   assign quotient    = quot_q;
   assign remainder   = remo_q;

endmodule

// File: tb/tb_seq_div_32bit.sv
// Directed bench for seq_div_32bit: vector table of divides plus handshake, re-start and reset sequences.
module tb_seq_div_32bit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] input1 = 32'd0;
   logic [31:0] input2 = 32'd0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } vec_t;

   vec_t vecs[10];

   seq_div_32bit dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .input1(input1),
      .input2(input2),
      .busy(busy),
      .done(done),
      .div_by_zero(div_by_zero),
      .quotient(quotient),
      .remainder(remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Start a divide, wait (bounded) for done, check latency, busy length, results and the single-cycle pulse.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz);
      int cycles;
      int busy_cnt;
      @(negedge clk);
      input1 = a;
      input2 = b;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      input1   = 32'hA5A5_A5A5;
      input2   = 32'h0000_0003;
      cycles   = 0;
      busy_cnt = 0;
      while (!done && cycles < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         cycles++;
      end
      check({tag, " latency"}, cycles, (b == 32'd0) ? 32'd0 : 32'd32);
      check({tag, " busy_cycles"}, busy_cnt, (b == 32'd0) ? 32'd0 : 32'd32);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edbz});
      @(negedge clk);
      check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
      check({tag, " quotient_held"}, quotient, eq);
   endtask

   initial begin
      vecs[0] = '{32'd100,       32'd7,        32'd14,        32'd2,        1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0};
      vecs[2] = '{32'd5,         32'd9,        32'd0,         32'd5,        1'b0};
      vecs[3] = '{32'd1234,      32'd0,        32'hFFFF_FFFF, 32'd1234,     1'b1};
      vecs[4] = '{32'd100,       32'd7,        32'd14,        32'd2,        1'b0};
      vecs[5] = '{32'd0,         32'd5,        32'd0,         32'd0,        1'b0};
`ifdef SEQ_DIV_SIGNED_EN
      vecs[6] = '{32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
      vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0};
      vecs[8] = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0};
      vecs[9] = '{32'hDEAD_BEEF, 32'h10,       32'hFDEA_DBEF, 32'hFFFF_FFFF, 1'b0};
`else
      vecs[6] = '{32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 32'd1,        1'b0};
      vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
      vecs[8] = '{32'd7,         32'hFFFF_FFFE, 32'd0,        32'd7,        1'b0};
      vecs[9] = '{32'hDEAD_BEEF, 32'h10,       32'h0DEA_DBEE, 32'hF,        1'b0};
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

      // Re-pulsed start during BUSY and during DONE must be ignored.
      begin
         int done_cnt;
         int done_at;
         int busy_cnt;
         @(negedge clk);
         input1 = 32'd100;
         input2 = 32'd7;
         start  = 1'b1;
         @(posedge clk);
         done_cnt = 0;
         done_at  = -1;
         busy_cnt = 0;
         for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
               done_cnt++;
               done_at = i;
            end
            if (busy) busy_cnt++;
            start  = (i == 4 || i == 32);
            input1 = start ? 32'd999 : 32'd100;
            input2 = start ? 32'd3 : 32'd7;
         end
         start = 1'b0;
         check("restart done_count", done_cnt, 32'd1);
         check("restart done_position", done_at, 32'd32);
         check("restart busy_cycles", busy_cnt, 32'd32);
         check("restart quotient", quotient, 32'd14);
         check("restart remainder", remainder, 32'd2);
      end

      // Asynchronous reset in the middle of a divide.
      begin
         int done_seen;
         @(negedge clk);
         input1 = 32'd100;
         input2 = 32'd7;
         start  = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         repeat (9) @(negedge clk);
         reset_n = 1'b0;
         #1;
         check("midreset busy", {31'd0, busy}, 32'd0);
         check("midreset done", {31'd0, done}, 32'd0);
         check("midreset quotient", quotient, 32'd0);
         check("midreset remainder", remainder, 32'd0);
         check("midreset div_by_zero", {31'd0, div_by_zero}, 32'd0);
         done_seen = 0;
         repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
         end
         reset_n = 1'b1;
         repeat (35) begin
            @(negedge clk);
            if (done || busy) done_seen++;
         end
         check("midreset no_done", done_seen, 32'd0);
         run_div("after_reset", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
